// File: rtl/ram_sched_pkg.sv
// Shared types and constants for the RAM round-robin scheduler.
// The lock-state encoding is always present; it is only reachable
// when RAM_RR_SCHED_LOCK_EN is defined.
package ram_sched_pkg;

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_SERVE  = 2'd1,
      ST_LOCKED = 2'd2
   } sched_state_t;

   localparam int unsigned DEF_ADDR_WIDTH = 6;
   localparam int unsigned DEPTH          = 1 << DEF_ADDR_WIDTH;

   // Memory depth for a given address width.
   function automatic int unsigned depth_of(input int unsigned aw);
      return 1 << aw;
   endfunction

endpackage

// File: rtl/ram_assign.sv
// Table RAM: one synchronous write port, one asynchronous read port.
// No reset on the storage; contents are defined by whoever writes it.
module ram_assign #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  write_en,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic [ADDR_WIDTH-1:0] read_addr,
   output logic [DATA_WIDTH-1:0] read_data
);

   logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

   // Write port: memory updates at the edge the write is presented.
   always_ff @(posedge clk) begin
      if (write_en) mem[write_addr] <= write_data;
   end

   assign read_data = mem[read_addr];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching upward from
// the registered pointer with wrap; pointer loads (advance_idx+1) mod
// NUM_REQ when advance is asserted, otherwise holds.
module rr_arbiter #(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] valid,
   input  logic               advance,
   input  logic [IDX_W-1:0]   advance_idx,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic [IDX_W-1:0]   pointer
);

   logic        found;
   int unsigned cand;

   // First valid requester at or above the pointer, wrapping around.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = (32'(pointer) + k) % NUM_REQ;
         if (!found && valid[IDX_W'(cand)]) begin
            found                  = 1'b1;
            grant[IDX_W'(cand)]    = 1'b1;
            grant_idx              = IDX_W'(cand);
         end
      end
   end

   // Rotating priority pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         pointer <= '0;
      end else if (advance) begin
         pointer <= (advance_idx == IDX_W'(NUM_REQ - 1)) ? '0 : advance_idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/ram_rr_scheduler.sv
// Shares one ram_assign between NUM_REQ requesters. After reset the RAM
// is zero-filled, then one access per cycle is granted round-robin and
// answered one cycle later with a tagged, registered response.
// Optional macro RAM_RR_SCHED_LOCK_EN adds req_lock and a LOCKED state in
// which the locking requester keeps exclusive access.
module ram_rr_scheduler
   import ram_sched_pkg::*;
#(
   parameter  int unsigned NUM_REQ    = 4,
   parameter  int unsigned ADDR_WIDTH = 6,
   parameter  int unsigned DATA_WIDTH = 64,
   parameter  int unsigned ID_WIDTH   = 2,
   localparam int unsigned IDX_W      = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0]            req_we,
`ifdef RAM_RR_SCHED_LOCK_EN
   input  logic [NUM_REQ-1:0]            req_lock,
`endif
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic                          rsp_valid,
   output logic                          rsp_we,
   output logic [ID_WIDTH-1:0]           rsp_id,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic                          init_done
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(depth_of(ADDR_WIDTH) - 1);

   sched_state_t state, state_nxt;
   logic [ADDR_WIDTH-1:0] fill_cnt;

   logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
   logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

   logic [NUM_REQ-1:0] arb_valid;
   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   gidx;
   logic [IDX_W-1:0]   rr_ptr;
   logic               adv;
   logic [IDX_W-1:0]   adv_idx;
   logic               accept;

   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_waddr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic [DATA_WIDTH-1:0] ram_rdata;

`ifdef RAM_RR_SCHED_LOCK_EN
   logic [IDX_W-1:0]   owner, owner_nxt;
   logic [NUM_REQ-1:0] owner_mask;
   assign owner_mask = NUM_REQ'(1) << owner;
`endif

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
   end

   assign sel_we    = req_we[gidx];
   assign sel_addr  = addr_arr[gidx];
   assign sel_wdata = wdata_arr[gidx];
   assign init_done = (state != ST_INIT);

   // Requests eligible for arbitration: none in reset/INIT, only the owner while locked.
   always_comb begin
      arb_valid = '0;
      if (!rst) begin
         if (state == ST_SERVE) arb_valid = req_valid;
`ifdef RAM_RR_SCHED_LOCK_EN
         if (state == ST_LOCKED) arb_valid = req_valid & owner_mask;
`endif
      end
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .clk         (clk),
      .rst         (rst),
      .valid       (arb_valid),
      .advance     (adv),
      .advance_idx (adv_idx),
      .grant       (grant),
      .grant_idx   (gidx),
      .pointer     (rr_ptr)
   );

   // Next state, grant handshake, pointer control and RAM write port.
   always_comb begin
      state_nxt = state;
      req_ready = '0;
      accept    = 1'b0;
      adv       = 1'b0;
      adv_idx   = gidx;
      ram_we    = 1'b0;
      ram_waddr = fill_cnt;
      ram_wdata = '0;
`ifdef RAM_RR_SCHED_LOCK_EN
      owner_nxt = owner;
`endif
      if (!rst) begin
         case (state)
            ST_INIT: begin
               ram_we = 1'b1;
               if (fill_cnt == LAST_ADDR) state_nxt = ST_SERVE;
            end
            ST_SERVE: begin
               req_ready = grant;
               accept    = |grant;
               adv       = accept;
`ifdef RAM_RR_SCHED_LOCK_EN
               // A locking acceptance parks the pointer until the lock is released.
               if (accept && req_lock[gidx]) begin
                  adv       = 1'b0;
                  owner_nxt = gidx;
                  state_nxt = ST_LOCKED;
               end
`endif
            end
`ifdef RAM_RR_SCHED_LOCK_EN
            ST_LOCKED: begin
               req_ready = grant;
               accept    = |grant;
               adv_idx   = owner;
               if (!req_valid[owner] || !req_lock[owner]) begin
                  adv       = 1'b1;
                  state_nxt = ST_SERVE;
               end
            end
`endif
            default: state_nxt = ST_INIT;
         endcase
         if (accept) begin
            ram_we    = sel_we;
            ram_waddr = sel_addr;
            ram_wdata = sel_wdata;
         end
      end
   end

   // State register and zero-fill counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_INIT;
         fill_cnt <= '0;
`ifdef RAM_RR_SCHED_LOCK_EN
         owner    <= '0;
`endif
      end else begin
         state <= state_nxt;
         if (state == ST_INIT) fill_cnt <= fill_cnt + ADDR_WIDTH'(1);
`ifdef RAM_RR_SCHED_LOCK_EN
         owner <= owner_nxt;
`endif
      end
   end

   // Registered response, one cycle after acceptance.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_we    <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= accept;
         rsp_we    <= accept & sel_we;
         rsp_id    <= accept ? ID_WIDTH'(gidx) : '0;
         rsp_data  <= (accept && !sel_we) ? ram_rdata : '0;
      end
   end

   ram_assign #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ram (
      .clk        (clk),
      .write_en   (ram_we),
      .write_addr (ram_waddr),
      .write_data (ram_wdata),
      .read_addr  (sel_addr),
      .read_data  (ram_rdata)
   );

endmodule

// File: tb/tb_ram_rr_scheduler.sv
// Self-checking bench for ram_rr_scheduler with a response scoreboard.
// Define RAM_RR_SCHED_LOCK_EN to also exercise the lock feature.
module tb_ram_rr_scheduler;

   localparam int unsigned NR    = 4;
   localparam int unsigned AW    = 6;
   localparam int unsigned DW    = 64;
   localparam int unsigned IW    = 2;
   localparam int unsigned DEPTH = 64;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NR-1:0]   req_valid = '0;
   logic [NR-1:0]   req_we    = '0;
   logic [NR*AW-1:0] req_addr = '0;
   logic [NR*DW-1:0] req_wdata = '0;
`ifdef RAM_RR_SCHED_LOCK_EN
   logic [NR-1:0]   req_lock  = '0;
`endif
   logic [NR-1:0]   req_ready;
   logic            rsp_valid;
   logic            rsp_we;
   logic [IW-1:0]   rsp_id;
   logic [DW-1:0]   rsp_data;
   logic            init_done;

   typedef struct {
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      bit            lock;
   } cmd_t;

   typedef struct {
      logic          we;
      int unsigned   id;
      logic [DW-1:0] data;
      int unsigned   cyc;
   } rsp_t;

   cmd_t cq [NR][$];
   rsp_t sb [$];
   rsp_t log_q [$];

   logic [DW-1:0] mem_m  [DEPTH];
   logic [AW-1:0] addr_a [NR];
   logic [DW-1:0] wd_a   [NR];

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned cyc   = 0;
   int unsigned m_fill = 0;
   int unsigned m_ptr  = 0;
   bit          m_locked = 1'b0;
   int unsigned m_owner  = 0;
   logic [NR-1:0] acc_n = '0;

   ram_rr_scheduler #(
      .NUM_REQ    (NR),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .ID_WIDTH   (IW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
`ifdef RAM_RR_SCHED_LOCK_EN
      .req_lock  (req_lock),
`endif
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_we    (rsp_we),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .init_done (init_done)
   );

   initial forever #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit bit_of(input logic [NR-1:0] v, input int unsigned i);
      logic [1:0] k;
      k = i[1:0];
      return v[k];
   endfunction

   always @(posedge clk) cyc++;

   // Requester driver: hold each command until accepted, then load the next.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NR; i++) begin
         cmd_t c;
         if (req_valid[i] && acc_n[i]) req_valid[i] = 1'b0;
         if (!req_valid[i] && cq[i].size() > 0) begin
            c = cq[i].pop_front();
            req_valid[i] = 1'b1;
            req_we[i]    = c.we;
            req_addr[i*AW +: AW]  = c.addr;
            req_wdata[i*DW +: DW] = c.data;
`ifdef RAM_RR_SCHED_LOCK_EN
            req_lock[i]  = c.lock;
`endif
         end
      end
   end

   // Reference model: fill timing, arbitration, memory contents, response scoreboard.
   always @(negedge clk) begin
      rsp_t e;
      int win;
      logic [NR-1:0] er;
      logic [1:0] wi;
      acc_n = req_valid & req_ready;
      for (int i = 0; i < NR; i++) begin
         addr_a[i] = req_addr[i*AW +: AW];
         wd_a[i]   = req_wdata[i*DW +: DW];
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check_val("rsp_valid", DW'(rsp_valid), DW'(1));
         check_val("rsp_we",    DW'(rsp_we),    DW'(e.we));
         check_val("rsp_id",    DW'(rsp_id),    DW'(e.id));
         check_val("rsp_data",  rsp_data,       e.data);
      end else if (rsp_valid !== 1'b0) begin
         check_val("rsp_spurious", DW'(rsp_valid), DW'(0));
      end
      if (rsp_valid === 1'b1) log_q.push_back('{rsp_we, int'(rsp_id), rsp_data, cyc});

      if (rst) begin
         m_fill = 0;
         m_ptr = 0;
         m_locked = 1'b0;
         sb.delete();
         for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
         check_val("ready_rst", DW'(req_ready), DW'(0));
      end else if (m_fill < DEPTH) begin
         check_val("init_done_lo", DW'(init_done), DW'(0));
         check_val("ready_init",   DW'(req_ready), DW'(0));
         m_fill++;
      end else begin
         check_val("init_done_hi", DW'(init_done), DW'(1));
         win = -1;
         if (m_locked) begin
`ifdef RAM_RR_SCHED_LOCK_EN
            if (bit_of(req_valid, m_owner)) begin
               win = int'(m_owner);
               if (!bit_of(req_lock, m_owner)) begin
                  m_locked = 1'b0;
                  m_ptr = (m_owner + 1) % NR;
               end
            end else begin
               m_locked = 1'b0;
               m_ptr = (m_owner + 1) % NR;
            end
`endif
         end else begin
            for (int k = 0; k < NR; k++) begin
               int unsigned c;
               c = (m_ptr + k) % NR;
               if (win < 0 && bit_of(req_valid, c)) win = int'(c);
            end
            if (win >= 0) begin
               m_ptr = (win + 1) % NR;
`ifdef RAM_RR_SCHED_LOCK_EN
               if (bit_of(req_lock, win)) begin
                  m_locked = 1'b1;
                  m_owner = win;
                  m_ptr = m_ptr;
               end
`endif
            end
         end
         er = '0;
         if (win >= 0) begin
            wi = win[1:0];
            er[wi] = 1'b1;
         end
         check_val("ready", DW'(req_ready), DW'(er));
         if (win >= 0) begin
            e.we  = req_we[wi];
            e.id  = win;
            e.cyc = 0;
            if (req_we[wi]) begin
               mem_m[addr_a[wi]] = wd_a[wi];
               e.data = '0;
            end else begin
               e.data = mem_m[addr_a[wi]];
            end
            sb.push_back(e);
         end
      end
   end

   task automatic push(input int unsigned r, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit lk);
      cq[r].push_back('{we, a, d, lk});
   endtask

   task automatic do_reset(input int unsigned n);
      rst = 1'b1;
      repeat (n) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wait_init(input string tag);
      int unsigned n = 0;
      bit seen = 1'b0;
      while (!seen && n < 200) begin
         @(posedge clk);
         #1;
         n++;
         if (init_done === 1'b1) seen = 1'b1;
      end
      check_val(tag, DW'(n), DW'(64));
   endtask

   task automatic drain(input string tag);
      bit done = 1'b0;
      for (int k = 0; k < 400 && !done; k++) begin
         @(negedge clk);
         #1;
         done = (req_valid == '0) && (sb.size() == 0);
         for (int i = 0; i < NR; i++) if (cq[i].size() != 0) done = 1'b0;
      end
      if (!done) check_val({tag, "_timeout"}, DW'(0), DW'(1));
   endtask

   task automatic check_log(input string tag, input int unsigned ids[$], input bit consec);
      int unsigned n;
      check_val({tag, "_cnt"}, DW'(log_q.size()), DW'(ids.size()));
      n = (log_q.size() < ids.size()) ? log_q.size() : ids.size();
      for (int i = 0; i < n; i++) begin
         check_val({tag, "_id"}, DW'(log_q[i].id), DW'(ids[i]));
         if (consec) check_val({tag, "_cyc"}, DW'(log_q[i].cyc), DW'(log_q[0].cyc + i));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      // Reset, zero-fill timing, reads of filled memory.
      do_reset(3);
      wait_init("init_len");
      log_q.delete();
      push(0, 1'b0, 6'd0,  '0, 1'b0);
      push(0, 1'b0, 6'd37, '0, 1'b0);
      push(0, 1'b0, 6'd63, '0, 1'b0);
      drain("zero_rd");
      check_log("zero_rd", '{0, 0, 0}, 1'b0);
      if (log_q.size() == 3) check_val("zero_rd_data37", log_q[1].data, '0);

      // Write then read-after-write from a different requester.
      log_q.delete();
      push(1, 1'b1, 6'd5, 64'hDEAD_BEEF_0000_0001, 1'b0);
      push(2, 1'b0, 6'd5, '0, 1'b0);
      drain("raw");
      check_log("raw", '{1, 2}, 1'b1);
      if (log_q.size() == 2) begin
         check_val("raw_ack_we",   DW'(log_q[0].we), DW'(1));
         check_val("raw_ack_data", log_q[0].data, '0);
         check_val("raw_rd_we",    DW'(log_q[1].we), DW'(0));
         check_val("raw_rd_data",  log_q[1].data, 64'hDEAD_BEEF_0000_0001);
      end

      // All four requesters at once from pointer 0.
      push(3, 1'b0, 6'd1, '0, 1'b0);
      drain("ptr0");
      log_q.delete();
      for (int i = 0; i < NR; i++) push(i, 1'b0, 6'(10 + i), '0, 1'b0);
      drain("rot");
      check_log("rot", '{0, 1, 2, 3}, 1'b1);

      // Wrap-around from pointer 2 with only req0/req3 valid.
      push(1, 1'b0, 6'd2, '0, 1'b0);
      drain("ptr2");
      log_q.delete();
      push(0, 1'b0, 6'd3, '0, 1'b0);
      push(3, 1'b1, 6'd4, 64'h1234_5678_9ABC_DEF0, 1'b0);
      drain("wrap");
      check_log("wrap", '{3, 0}, 1'b1);

      // Reset mid-fill with a request pending; fill restarts from zero.
      do_reset(2);
      repeat (20) @(posedge clk);
      #2;
      log_q.delete();
      push(0, 1'b0, 6'd4, '0, 1'b0);
      do_reset(2);
      wait_init("refill_len");
      drain("refill");
      check_log("refill", '{0}, 1'b0);
      if (log_q.size() == 1) check_val("refill_data", log_q[0].data, '0);

`ifdef RAM_RR_SCHED_LOCK_EN
      // Locked burst by req1 while req0 and req2 wait.
      log_q.delete();
      push(0, 1'b0, 6'd20, '0, 1'b0);
      push(2, 1'b0, 6'd21, '0, 1'b0);
      push(1, 1'b1, 6'd30, 64'h11, 1'b1);
      push(1, 1'b1, 6'd31, 64'h22, 1'b1);
      push(1, 1'b1, 6'd32, 64'h33, 1'b0);
      drain("lock");
      check_log("lock", '{1, 1, 1, 2, 0}, 1'b1);
      log_q.delete();
      push(2, 1'b0, 6'd31, '0, 1'b0);
      drain("lock_rd");
      if (log_q.size() == 1) check_val("lock_rd_data", log_q[0].data, 64'h22);
      else check_val("lock_rd_cnt", DW'(log_q.size()), DW'(1));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_rr_scheduler.md
Name: ram_rr_scheduler

Overview:
- Shares one ram_assign instance (single write port, single asynchronous read port) between NUM_REQ requesters.
- After reset, zero-fills the whole memory, then grants one access per cycle in round-robin order.
- Returns registered read data and write acknowledgements tagged with the requester index.
- Sits between MMU table clients (walker, allocator, config) and the table RAM.

Parameters:
- NUM_REQ, 4: number of requesters; ≥2.
- ADDR_WIDTH, 6: RAM address width; depth is 1<<ADDR_WIDTH.
- DATA_WIDTH, 64: RAM word width.
- ID_WIDTH, 2: width of the response tag; must satisfy 2^ID_WIDTH ≥ NUM_REQ.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant/accept.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i is at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- rsp_valid  out  1  response valid, one-cycle pulse, no backpressure.
- rsp_we  out  1  response is a write acknowledgement.
- rsp_id  out  ID_WIDTH  index of the requester being answered.
- rsp_data  out  DATA_WIDTH  read data; zero for write acknowledgements.
- init_done  out  1  high once zero-fill has completed.

Behaviour:
- Reset: all registered state is updated on posedge clk while rst=1.
  - FSM goes to INIT; fill counter = 0; rr pointer = 0.
  - rsp_valid=0, rsp_we=0, rsp_id=0, rsp_data=0, init_done=0.
  - req_ready=0 while rst=1.
  - Reset asserted mid-fill or mid-service restarts the fill from address 0. Any accepted-but-unanswered response is dropped.
- FSM INIT:
  - Each cycle drives write_en=1, write_addr=fill counter, write_data=0, then increments the counter.
  - req_ready=0 throughout.
  - After the write to address (1<<ADDR_WIDTH)-1, go to SERVE. init_done=1 from the first SERVE cycle.
  - Fill takes exactly 1<<ADDR_WIDTH cycles.
- FSM SERVE: stays in SERVE until rst.
- Grant:
  - Combinational. Pick the first i with req_valid[i]=1, searching from pointer upward with wrap.
  - req_ready = one-hot of the winner; all zero if no request is valid.
  - At most one grant per cycle.
  - Handshake: a request is accepted when valid & ready. Requesters must hold addr/data/we stable while valid is high and not yet accepted.
- Pointer: on acceptance from requester g, pointer ← (g+1) mod NUM_REQ. With no acceptance, the pointer holds.
- Write: on acceptance, write_en=1 to the RAM the same cycle; memory updates at that edge.
- Read: RAM read_addr = winner's address. On the accepting edge, rsp_data ← read_data.
- Response latency: exactly 1 cycle after acceptance.
  - rsp_valid=1 and rsp_id=g for that single cycle.
  - rsp_we = the accepted request's we.
  - rsp_data = 0 for writes.
- Read-after-write: a write accepted at cycle n is visible to a read accepted at cycle n+1 or later, regardless of requester.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0,…; no requester waits more than NUM_REQ-1 cycles.
- Requests valid during INIT stay pending and are served in rr order starting from pointer 0.

Optional Feature:
- Macro: RAM_RR_SCHED_LOCK_EN.
- When defined, adds port req_lock (in, NUM_REQ) and a LOCKED FSM state.
  - If accepted requester g has req_lock[g]=1, go to LOCKED(owner=g); the pointer is not advanced.
  - In LOCKED, only g may be granted; other requesters see ready=0.
  - Exit to SERVE on the first cycle g is valid with req_lock[g]=0 and is accepted; that access is granted, then pointer ← g+1.
  - Also exit to SERVE when g drops req_valid. In that case the pointer ← g+1 and nothing is granted that cycle.
  - rst clears the lock.
- When not defined: no req_lock port and no LOCKED state; pure round-robin.

Decomposition:
- Package ram_sched_pkg:
  - FSM state encodings ST_INIT, ST_SERVE, ST_LOCKED.
  - Helper constant DEPTH = 1<<ADDR_WIDTH.
- Sub-module rr_arbiter (NUM_REQ): inputs valid vector, pointer, advance. Outputs one-hot grant, grant index, and the registered pointer.
- ram_assign is instantiated, not reimplemented.

Test Plan:
- Reset then idle, ADDR_WIDTH=6 → init_done rises exactly 64 cycles after rst release; reads of addresses 0, 37, 63 return rsp_data=0.
- Req1 writes addr 5 = 0xDEAD_BEEF_0000_0001; next cycle req2 reads addr 5 → write ack (rsp_id=1, rsp_we=1) one cycle after the write; read response rsp_id=2, rsp_data=0xDEAD_BEEF_0000_0001 one cycle after the read.
- All 4 requesters hold reads of distinct addresses → grants 0,1,2,3 in consecutive cycles; rsp_id follows 0,1,2,3 each one cycle later.
- Pointer=2, only req0 and req3 valid → req3 granted first, then req0.
- Assert rst during fill (counter=20) → init_done stays 0; fill restarts and completes 64 cycles after release; a pending response is not emitted.
- LOCK_EN: req1 locks for 3 writes while req0 and req2 are valid → req1 granted 3 consecutive cycles; req2 granted next, then req0.
